// File: rtl/ps2_input_mapper.sv
// ps2_input_mapper
// Turns PS/2 keyboard events and the combined joystick word into registered
// arcade cabinet controls for two players. Player directions can be rotated
// for horizontally mounted games. Coin presses are stretched to a minimum
// number of VSync periods so that short pulses still register with the game.
module ps2_input_mapper #(
   parameter int COIN_FRAMES = 3
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joy,
   input  logic        horz,
   input  logic        vs,
   output logic        up1,
   output logic        down1,
   output logic        left1,
   output logic        right1,
   output logic        gas1,
   output logic        brake1,
   output logic        up2,
   output logic        down2,
   output logic        left2,
   output logic        right2,
   output logic        gas2,
   output logic        brake2,
   output logic        start1,
   output logic        start2,
   output logic        coin
);

   // Positions of the individual key latches inside key_q
   localparam logic [3:0] K_UP     = 4'd0;
   localparam logic [3:0] K_DOWN   = 4'd1;
   localparam logic [3:0] K_LEFT   = 4'd2;
   localparam logic [3:0] K_RIGHT  = 4'd3;
   localparam logic [3:0] K_GAS    = 4'd4;
   localparam logic [3:0] K_BRAKE  = 4'd5;
   localparam logic [3:0] K_START1 = 4'd6;
   localparam logic [3:0] K_START2 = 4'd7;
   localparam logic [3:0] K_COIN1  = 4'd8;
   localparam logic [3:0] K_COIN2  = 4'd9;
   localparam logic [3:0] K_UP2    = 4'd10;
   localparam logic [3:0] K_DOWN2  = 4'd11;
   localparam logic [3:0] K_LEFT2  = 4'd12;
   localparam logic [3:0] K_RIGHT2 = 4'd13;
   localparam logic [3:0] K_GAS2   = 4'd14;
   localparam logic [3:0] K_BRAKE2 = 4'd15;

   localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES);

   logic        key_toggle;
   logic        key_pressed;
   logic        key_ext;
   logic [7:0]  key_code;

   logic        toggle_q;
   logic        primed_q;
   logic        key_event;
   logic        key_hit;
   logic [3:0]  key_idx;
   logic [15:0] key_q;

   logic        dir_up1;
   logic        dir_down1;
   logic        dir_left1;
   logic        dir_right1;
   logic        dir_up2;
   logic        dir_down2;
   logic        dir_left2;
   logic        dir_right2;

   logic        coin_raw;
   logic        coin_raw_q;
   logic        coin_rise;
   logic        vs_q;
   logic        vs_rise;
   logic [3:0]  coin_cnt;

   logic        unused_joy;

   assign key_toggle  = ps2_key[10];
   assign key_pressed = ps2_key[9];
   assign key_ext     = ps2_key[8];
   assign key_code    = ps2_key[7:0];

   // The upper joystick bits carry buttons this cabinet has no use for
   assign unused_joy = ^joy[15:9];

   // A new keyboard event is signalled by a change of the toggle bit. Right
   // after reset the previous toggle value is unknown, so the first edge only
   // captures it and no event is decoded.
   assign key_event = primed_q & (key_toggle ^ toggle_q);

   // Track the toggle bit and note when the first post-reset edge has passed
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         toggle_q <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         toggle_q <= key_toggle;
         primed_q <= 1'b1;
      end
   end

   // Translate the scan code into a latch index; arrows accept both the
   // plain and the extended form, everything else must be non-extended
   always_comb begin
      key_hit = 1'b0;
      key_idx = K_UP;
      case (key_code)
         8'h75: begin key_hit = 1'b1;     key_idx = K_UP;     end
         8'h72: begin key_hit = 1'b1;     key_idx = K_DOWN;   end
         8'h6B: begin key_hit = 1'b1;     key_idx = K_LEFT;   end
         8'h74: begin key_hit = 1'b1;     key_idx = K_RIGHT;  end
         8'h29: begin key_hit = !key_ext; key_idx = K_GAS;    end
         8'h14: begin key_hit = !key_ext; key_idx = K_BRAKE;  end
         8'h05: begin key_hit = !key_ext; key_idx = K_START1; end
         8'h16: begin key_hit = !key_ext; key_idx = K_START1; end
         8'h06: begin key_hit = !key_ext; key_idx = K_START2; end
         8'h1E: begin key_hit = !key_ext; key_idx = K_START2; end
         8'h2E: begin key_hit = !key_ext; key_idx = K_COIN1;  end
         8'h36: begin key_hit = !key_ext; key_idx = K_COIN2;  end
         8'h2D: begin key_hit = !key_ext; key_idx = K_UP2;    end
         8'h2B: begin key_hit = !key_ext; key_idx = K_DOWN2;  end
         8'h23: begin key_hit = !key_ext; key_idx = K_LEFT2;  end
         8'h34: begin key_hit = !key_ext; key_idx = K_RIGHT2; end
         8'h1C: begin key_hit = !key_ext; key_idx = K_GAS2;   end
         8'h1B: begin key_hit = !key_ext; key_idx = K_BRAKE2; end
         default: begin
            key_hit = 1'b0;
            key_idx = K_UP;
         end
      endcase
   end

   // Store the pressed/released state of a mapped key when its event arrives;
   // a repeated press just rewrites the same value
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         key_q <= '0;
      end else if (key_event && key_hit) begin
         key_q[key_idx] <= key_pressed;
      end
   end

   // Merge keys with the joystick and rotate directions for horizontal games
   always_comb begin
      dir_up1    = key_q[K_UP]     | joy[3];
      dir_down1  = key_q[K_DOWN]   | joy[2];
      dir_left1  = key_q[K_LEFT]   | joy[1];
      dir_right1 = key_q[K_RIGHT]  | joy[0];
      dir_up2    = key_q[K_UP2]    | joy[3];
      dir_down2  = key_q[K_DOWN2]  | joy[2];
      dir_left2  = key_q[K_LEFT2]  | joy[1];
      dir_right2 = key_q[K_RIGHT2] | joy[0];
      if (horz) begin
         dir_up1    = key_q[K_LEFT]   | joy[1];
         dir_down1  = key_q[K_RIGHT]  | joy[0];
         dir_left1  = key_q[K_DOWN]   | joy[2];
         dir_right1 = key_q[K_UP]     | joy[3];
         dir_up2    = key_q[K_LEFT2]  | joy[1];
         dir_down2  = key_q[K_RIGHT2] | joy[0];
         dir_left2  = key_q[K_DOWN2]  | joy[2];
         dir_right2 = key_q[K_UP2]    | joy[3];
      end
   end

   // Register every player and cabinet control so outputs are glitch free
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         up1    <= 1'b0;
         down1  <= 1'b0;
         left1  <= 1'b0;
         right1 <= 1'b0;
         gas1   <= 1'b0;
         brake1 <= 1'b0;
         up2    <= 1'b0;
         down2  <= 1'b0;
         left2  <= 1'b0;
         right2 <= 1'b0;
         gas2   <= 1'b0;
         brake2 <= 1'b0;
         start1 <= 1'b0;
         start2 <= 1'b0;
      end else begin
         up1    <= dir_up1;
         down1  <= dir_down1;
         left1  <= dir_left1;
         right1 <= dir_right1;
         gas1   <= key_q[K_GAS]    | joy[4];
         brake1 <= key_q[K_BRAKE]  | joy[5];
         up2    <= dir_up2;
         down2  <= dir_down2;
         left2  <= dir_left2;
         right2 <= dir_right2;
         gas2   <= key_q[K_GAS2]   | joy[4];
         brake2 <= key_q[K_BRAKE2] | joy[5];
         start1 <= key_q[K_START1] | joy[6];
         start2 <= key_q[K_START2] | joy[7];
      end
   end

   assign coin_raw  = key_q[K_COIN1] | key_q[K_COIN2] | joy[8];
   assign coin_rise = coin_raw & ~coin_raw_q;
   assign vs_rise   = vs & ~vs_q;

   // Remember last coin request and VSync level for edge detection
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_raw_q <= 1'b0;
         vs_q       <= 1'b0;
      end else begin
         coin_raw_q <= coin_raw;
         vs_q       <= vs;
      end
   end

   // Coin stretch counter: a fresh coin press reloads it, even mid-count and
   // even when a frame boundary lands on the same edge; otherwise it counts
   // down once per frame until empty
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_cnt <= 4'd0;
      end else if (coin_rise) begin
         coin_cnt <= COIN_LOAD;
      end else if (vs_rise && coin_cnt != 4'd0) begin
         coin_cnt <= coin_cnt - 4'd1;
      end
   end

   // Coin stays active while the request is held or the stretch is running
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin <= 1'b0;
      end else begin
         coin <= (coin_cnt != 4'd0) | coin_raw;
      end
   end

endmodule

// File: tb/tb_ps2_input_mapper.sv
// tb_ps2_input_mapper
// Directed self-checking bench for ps2_input_mapper with default COIN_FRAMES.
module tb_ps2_input_mapper;

   // Bit positions in the packed output vector used for comparisons
   localparam logic [14:0] O_UP1    = 15'h4000;
   localparam logic [14:0] O_DOWN1  = 15'h2000;
   localparam logic [14:0] O_LEFT1  = 15'h1000;
   localparam logic [14:0] O_RIGHT1 = 15'h0800;
   localparam logic [14:0] O_GAS1   = 15'h0400;
   localparam logic [14:0] O_BRAKE1 = 15'h0200;
   localparam logic [14:0] O_UP2    = 15'h0100;
   localparam logic [14:0] O_DOWN2  = 15'h0080;
   localparam logic [14:0] O_LEFT2  = 15'h0040;
   localparam logic [14:0] O_RIGHT2 = 15'h0020;
   localparam logic [14:0] O_GAS2   = 15'h0010;
   localparam logic [14:0] O_BRAKE2 = 15'h0008;
   localparam logic [14:0] O_START1 = 15'h0004;
   localparam logic [14:0] O_START2 = 15'h0002;
   localparam logic [14:0] O_COIN   = 15'h0001;
   localparam logic [14:0] O_NONE   = 15'h0000;

   logic        clk_sys;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic [15:0] joy;
   logic        horz;
   logic        vs;
   logic        up1, down1, left1, right1, gas1, brake1;
   logic        up2, down2, left2, right2, gas2, brake2;
   logic        start1, start2, coin;

   logic [14:0] outs;
   logic        tog;
   int          checks;
   int          errors;

   ps2_input_mapper dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ps2_key (ps2_key),
      .joy     (joy),
      .horz    (horz),
      .vs      (vs),
      .up1     (up1),
      .down1   (down1),
      .left1   (left1),
      .right1  (right1),
      .gas1    (gas1),
      .brake1  (brake1),
      .up2     (up2),
      .down2   (down2),
      .left2   (left2),
      .right2  (right2),
      .gas2    (gas2),
      .brake2  (brake2),
      .start1  (start1),
      .start2  (start2),
      .coin    (coin)
   );

   assign outs = {up1, down1, left1, right1, gas1, brake1,
                  up2, down2, left2, right2, gas2, brake2,
                  start1, start2, coin};

   // 100 MHz system clock
   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // Advance n rising edges, leaving time 1 ns past the last edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Drive joystick, rotation and VSync levels
   task automatic applyStimulus(input logic [15:0] j, input logic h, input logic v);
      joy  = j;
      horz = h;
      vs   = v;
   endtask

   // Present a new keyboard event by flipping the toggle bit
   task automatic sendKey(input logic pressed, input logic ext, input logic [7:0] code);
      tog     = ~tog;
      ps2_key = {tog, pressed, ext, code};
   endtask

   // One VSync high cycle followed by one low cycle
   task automatic vsPulse();
      vs = 1'b1;
      tick(1);
      vs = 1'b0;
      tick(1);
   endtask

   // Compare the packed outputs against the expected pattern
   task automatic checkOutput(input string tag, input logic [14:0] exp);
      checks++;
      assert (outs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, outs, exp);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      tog     = 1'b1;
      reset_n = 1'b0;
      ps2_key = 11'h629;
      applyStimulus(16'h0000, 1'b0, 1'b0);
      tick(3);
      checkOutput("reset_state", O_NONE);

      // Release with a stale gas press showing; the prime edge must swallow it
      reset_n = 1'b1;
      tick(4);
      checkOutput("stale_key_after_release", O_NONE);

      // Gas press then release, two edges each
      sendKey(1'b1, 1'b0, 8'h29);
      tick(1);
      checkOutput("gas_press_one_edge", O_NONE);
      tick(1);
      checkOutput("gas_press_two_edges", O_GAS1);
      sendKey(1'b0, 1'b0, 8'h29);
      tick(1);
      checkOutput("gas_release_one_edge", O_GAS1);
      tick(1);
      checkOutput("gas_release_two_edges", O_NONE);

      // Extended left arrow with rotation, then unrotated
      applyStimulus(16'h0000, 1'b1, 1'b0);
      sendKey(1'b1, 1'b1, 8'h6B);
      tick(2);
      checkOutput("left_key_rotated", O_UP1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      tick(1);
      checkOutput("left_key_unrotated", O_LEFT1);
      sendKey(1'b0, 1'b0, 8'h6B);
      tick(2);
      checkOutput("left_key_released", O_NONE);

      // Joystick directions and buttons, both orientations
      applyStimulus(16'h0001, 1'b0, 1'b0);
      tick(1);
      checkOutput("joy_right", O_RIGHT1 | O_RIGHT2);
      applyStimulus(16'h0001, 1'b1, 1'b0);
      tick(1);
      checkOutput("joy_right_rotated", O_DOWN1 | O_DOWN2);
      applyStimulus(16'h0008, 1'b1, 1'b0);
      tick(1);
      checkOutput("joy_up_rotated", O_RIGHT1 | O_RIGHT2);
      applyStimulus(16'h00F0, 1'b0, 1'b0);
      tick(1);
      checkOutput("joy_buttons", O_GAS1 | O_BRAKE1 | O_GAS2 | O_BRAKE2 | O_START1 | O_START2);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      tick(1);
      checkOutput("joy_cleared", O_NONE);

      // Player-2 up; an extended variant of the same code is not mapped
      sendKey(1'b1, 1'b0, 8'h2D);
      tick(2);
      checkOutput("p2_up_press", O_UP2);
      sendKey(1'b0, 1'b1, 8'h2D);
      tick(2);
      checkOutput("p2_up_ext_release_ignored", O_UP2);
      sendKey(1'b0, 1'b0, 8'h2D);
      tick(2);
      checkOutput("p2_up_release", O_NONE);

      // Repeated start1 press, released through the alias code
      sendKey(1'b1, 1'b0, 8'h05);
      tick(2);
      sendKey(1'b1, 1'b0, 8'h05);
      tick(2);
      checkOutput("start1_repeat_press", O_START1);
      sendKey(1'b0, 1'b0, 8'h16);
      tick(2);
      checkOutput("start1_alias_release", O_NONE);

      // Unmapped code changes nothing
      sendKey(1'b1, 1'b0, 8'hAA);
      tick(3);
      checkOutput("unmapped_press", O_NONE);

      // Single-cycle coin pulse stretched over three frames
      applyStimulus(16'h0100, 1'b0, 1'b0);
      tick(1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      checkOutput("coin_pulse_start", O_COIN);
      tick(1);
      vsPulse();
      checkOutput("coin_after_vs1", O_COIN);
      vsPulse();
      checkOutput("coin_after_vs2", O_COIN);
      vs = 1'b1;
      tick(1);
      vs = 1'b0;
      tick(1);
      checkOutput("coin_after_vs3", O_NONE);

      // Reload wins over a coincident frame decrement at count 1
      applyStimulus(16'h0100, 1'b0, 1'b0);
      tick(1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      tick(1);
      vsPulse();
      vsPulse();
      applyStimulus(16'h0100, 1'b0, 1'b1);
      tick(1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      tick(1);
      checkOutput("coin_reload_coincident", O_COIN);
      vsPulse();
      vsPulse();
      checkOutput("coin_reload_two_frames", O_COIN);
      vsPulse();
      checkOutput("coin_reload_three_frames", O_NONE);

      // Held keyboard coin keeps coin high without retriggering
      sendKey(1'b1, 1'b0, 8'h2E);
      tick(2);
      checkOutput("coin_key_held", O_COIN);
      for (int i = 0; i < 4; i++) vsPulse();
      checkOutput("coin_key_held_frames", O_COIN);
      sendKey(1'b0, 1'b0, 8'h2E);
      tick(2);
      checkOutput("coin_key_released", O_NONE);

      // Reset in the middle of a coin pulse abandons it
      applyStimulus(16'h0100, 1'b0, 1'b0);
      tick(1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
      tick(1);
      checkOutput("coin_before_reset", O_COIN);
      reset_n = 1'b0;
      #1;
      checkOutput("coin_during_reset", O_NONE);
      tick(1);
      reset_n = 1'b1;
      tick(3);
      checkOutput("coin_after_reset", O_NONE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_input_mapper.md
PS2_INPUT_MAPPER -- requirements
Module: ps2_input_mapper

Interface
REQ-001 SHALL have parameter COIN_FRAMES, default 3: minimum coin pulse length in VSync periods, range 1..15.
REQ-002 SHALL have port clk_sys, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port ps2_key, input, 11: [10] event toggle, [9] pressed, [8] extended flag, [7:0] scan code.
REQ-005 SHALL have port joy, input, 16: OR of both joysticks; [0]R [1]L [2]D [3]U [4]gas [5]brake [6]start1 [7]start2 [8]coin.
REQ-006 SHALL have port horz, input, 1: 1 selects the rotated (horizontal) direction mapping.
REQ-007 SHALL have port vs, input, 1: video VSync, synchronous to clk_sys, active high.
REQ-008 SHALL have ports up1, down1, left1, right1, gas1, brake1, output, 1 each: player-1 controls.
REQ-009 SHALL have ports up2, down2, left2, right2, gas2, brake2, output, 1 each: player-2 controls.
REQ-010 SHALL have ports start1, start2, coin, output, 1 each: cabinet controls.

Function
REQ-011 SHALL hold 16 key latches: up, down, left, right, gas, brake, start1, start2, coin1, coin2, up2, down2, left2, right2, gas2, brake2.
REQ-012 SHALL register toggle_q <= ps2_key[10] every cycle; an event is a cycle where ps2_key[10] != toggle_q.
REQ-013 SHALL suppress event decode on the first clock edge after reset release (prime cycle); that edge only loads toggle_q.
REQ-014 SHALL, on an event, write ps2_key[9] into the latch selected by {ps2_key[8],ps2_key[7:0]}; unmapped codes change nothing.
REQ-015 SHALL map arrows ignoring bit 8: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
REQ-016 SHALL map with bit 8 = 0: 0x29 gas, 0x14 brake, 0x05/0x16 start1, 0x06/0x1E start2, 0x2E coin1, 0x36 coin2, 0x2D up2, 0x2B down2, 0x23 left2, 0x34 right2, 0x1C gas2, 0x1B brake2.
REQ-017 SHALL, for player n with horz=0: up=kup|joy[3], down=kdown|joy[2], left=kleft|joy[1], right=kright|joy[0].
REQ-018 SHALL, for player n with horz=1: up=kleft|joy[1], down=kright|joy[0], left=kdown|joy[2], right=kup|joy[3].
REQ-019 SHALL drive gasn=kgasn|joy[4], brakern=kbraken|joy[5], start1=kstart1|joy[6], start2=kstart2|joy[7].
REQ-020 SHALL register all outputs; joy/horz change visible after 1 edge, key event visible 1 edge after the latch update edge.
REQ-021 SHALL form coin_raw = kcoin1|kcoin2|joy[8] and register coin_raw_q for edge detection.
REQ-022 SHALL use a 4-bit coin counter: on coin_raw rising edge load COIN_FRAMES; else on vs rising edge, if nonzero, decrement.
REQ-023 SHALL give reload priority when a coin_raw rise and a vs rise coincide.
REQ-024 SHALL drive coin = (counter != 0) | coin_raw, registered.
REQ-025 SHALL not retrigger while coin_raw stays high; a new rise while counting reloads COIN_FRAMES.
REQ-026 SHALL treat a repeated press event for an already-pressed key as idempotent.

Reset
REQ-027 SHALL, while reset_n=0, clear all latches, toggle_q, coin_raw_q, vs delay, coin counter, prime flag and all outputs to 0.
REQ-028 SHALL abandon any in-progress coin pulse on reset; coin is 0 one cycle after reset assertion at most.

Verification
REQ-029 Reset release with ps2_key=0x4xx stale (toggle=1) -> no latch changes; all outputs 0.
REQ-030 Event {1,1,0x029}, then {0,0,0x029} -> gas1=1 two edges after first event, 0 two edges after second.
REQ-031 horz=1, event press 0x16B (left, extended) -> up1=1, left1=0; horz=0 same latch -> left1=1.
REQ-032 Single-cycle joy[8] pulse, COIN_FRAMES=3 -> coin high until third vs rising edge, then 0.
REQ-033 coin_raw rise on same cycle as vs rise with counter=1 -> counter=3, coin stays 1.
REQ-034 Unmapped event 0x0AA press -> no output change; reset_n low mid coin pulse -> coin=0, counter=0.
